// File: rtl/pn2112_descrambler.sv
// PN-2112 block descrambler for the 10GBASE-R FEC receive path.
// Ports: clk, arst, din/din_valid/din_sob in; dout/dout_valid/dout_sob/
//   dout_eob/word_idx/align_err out. Macro PN2112_CHECK_EN adds
//   chk_clr (in) and chk_err_cnt (out, saturating popcount of dout).
module pn2112_descrambler #(
  parameter logic [57:0] SEED            = 58'h2aaaaaaaaaaaaaa,
  parameter int          WORDS_PER_BLOCK = 66
) (
  input  logic        clk,
  input  logic        arst,
`ifdef PN2112_CHECK_EN
  input  logic        chk_clr,
  output logic [31:0] chk_err_cnt,
`endif
  input  logic [31:0] din,
  input  logic        din_valid,
  input  logic        din_sob,
  output logic [31:0] dout,
  output logic        dout_valid,
  output logic        dout_sob,
  output logic        dout_eob,
  output logic [6:0]  word_idx,
  output logic        align_err
);

  typedef enum logic {HUNT, IN_BLOCK} state_t;

  localparam logic [6:0] LAST_IDX = 7'(WORDS_PER_BLOCK - 1);

  // 32 LFSR steps: PN word for the current state.
  function automatic logic [31:0] pn_word(input logic [57:0] s_in);
    logic [57:0] s;
    logic [31:0] w;
    logic        o;
    s = s_in;
    w = '0;
    for (int i = 0; i < 32; i++) begin
      o    = s[57] ^ s[38];
      w[i] = o;
      s    = {s[56:0], o};
    end
    return w;
  endfunction

  // 32 LFSR steps: state after the word.
  function automatic logic [57:0] pn_adv(input logic [57:0] s_in);
    logic [57:0] s;
    s = s_in;
    for (int i = 0; i < 32; i++) begin
      s = {s[56:0], s[57] ^ s[38]};
    end
    return s;
  endfunction

  state_t      state_q, state_d;
  logic [57:0] lfsr_q, lfsr_d;
  logic [6:0]  idx_q, idx_d;

  logic        emit;
  logic        last;
  logic [6:0]  cur_idx;
  logic [57:0] src;
  logic [31:0] pn_w;

  logic [31:0] dout_d;
  logic        valid_d, sob_d, eob_d, err_d;
  logic [6:0]  widx_d;

  // A sob always restarts from SEED, even mid-block.
  assign src     = din_sob ? SEED : lfsr_q;
  assign pn_w    = pn_word(src);
  assign emit    = din_valid & (din_sob | (state_q == IN_BLOCK));
  assign cur_idx = din_sob ? 7'd0 : idx_q;
  assign last    = emit & (cur_idx == LAST_IDX);

  // State register
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= HUNT;
      lfsr_q  <= SEED;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    idx_d   = idx_q;
    if (emit) begin
      if (last) begin
        state_d = HUNT;
        lfsr_d  = SEED;
        idx_d   = '0;
      end else begin
        state_d = IN_BLOCK;
        lfsr_d  = pn_adv(src);
        idx_d   = cur_idx + 7'd1;
      end
    end
  end

  // Output logic
  always_comb begin
    dout_d  = dout;
    valid_d = emit;
    sob_d   = emit & din_sob;
    eob_d   = last;
    widx_d  = emit ? cur_idx : 7'd0;
    err_d   = emit & din_sob & (state_q == IN_BLOCK);
    if (emit) begin
      dout_d = din ^ pn_w;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_sob   <= 1'b0;
      dout_eob   <= 1'b0;
      word_idx   <= '0;
      align_err  <= 1'b0;
    end else begin
      dout       <= dout_d;
      dout_valid <= valid_d;
      dout_sob   <= sob_d;
      dout_eob   <= eob_d;
      word_idx   <= widx_d;
      align_err  <= err_d;
    end
  end

`ifdef PN2112_CHECK_EN
  logic [5:0]  ones;
  logic [32:0] sum;

  always_comb begin
    ones = '0;
    for (int i = 0; i < 32; i++) begin
      ones = ones + {5'd0, dout_d[i]};
    end
  end

  assign sum = {1'b0, chk_err_cnt} + {27'd0, ones};

  // Counts in step with the word being registered onto dout.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      chk_err_cnt <= '0;
    end else if (chk_clr) begin
      chk_err_cnt <= '0;
    end else if (valid_d) begin
      chk_err_cnt <= sum[32] ? 32'hFFFFFFFF : sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_pn2112_descrambler.sv
// Directed/randomized bench for pn2112_descrambler against a
// bit-stream PN model and a block-position reference model.
module tb_pn2112_descrambler;

  localparam logic [57:0] SEED = 58'h2aaaaaaaaaaaaaa;

  logic        clk = 1'b0;
  logic        arst;
  logic [31:0] din;
  logic        din_valid;
  logic        din_sob;
  logic [31:0] dout;
  logic        dout_valid;
  logic        dout_sob;
  logic        dout_eob;
  logic [6:0]  word_idx;
  logic        align_err;
`ifdef PN2112_CHECK_EN
  logic        chk_clr;
  logic [31:0] chk_err_cnt;
`endif

  always #5 clk = ~clk;

  pn2112_descrambler dut (
    .clk        (clk),
    .arst       (arst),
`ifdef PN2112_CHECK_EN
    .chk_clr    (chk_clr),
    .chk_err_cnt(chk_err_cnt),
`endif
    .din        (din),
    .din_valid  (din_valid),
    .din_sob    (din_sob),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_sob   (dout_sob),
    .dout_eob   (dout_eob),
    .word_idx   (word_idx),
    .align_err  (align_err)
  );

  int tests = 0;
  int fails = 0;

  logic [31:0] pn [66];

  // Reference model: inside-block flag and next word position.
  bit m_in;
  int m_idx;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // PN as a bit stream: b[0..57] is the seed read MSB first,
  // then b[58+t] = b[t] ^ b[t+19] is PN bit t.
  task automatic build_pn();
    bit          b [2170];
    logic [57:0] sv;
    sv = SEED;
    for (int k = 0; k < 58; k++) b[k] = sv[57-k];
    for (int t = 0; t < 2112; t++) b[58+t] = b[t] ^ b[t+19];
    for (int n = 0; n < 66; n++) begin
      pn[n] = '0;
      for (int j = 0; j < 32; j++) pn[n][j] = b[58 + 32*n + j];
    end
  endtask

  task automatic cyc(input bit v, input bit s, input logic [31:0] d);
    bit          ev, es, ee, er;
    logic [6:0]  ei;
    logic [31:0] ed;
    ev = 0; es = 0; ee = 0; er = 0; ei = '0; ed = '0;
    if (v && s) begin
      ev = 1; es = 1; er = m_in; ei = 7'd0; ed = d ^ pn[0];
      m_in = 1; m_idx = 1;
    end else if (v && m_in) begin
      ev = 1; ei = 7'(m_idx); ed = d ^ pn[m_idx];
      ee = (m_idx == 65);
      m_idx++;
      if (m_idx == 66) begin
        m_in = 0; m_idx = 0;
      end
    end
    din_valid = v; din_sob = s; din = d;
    @(posedge clk); #1;
    chk("dout_valid", {31'd0, dout_valid}, {31'd0, ev});
    if (ev) chk("dout", dout, ed);
    chk("dout_sob", {31'd0, dout_sob}, {31'd0, es});
    chk("dout_eob", {31'd0, dout_eob}, {31'd0, ee});
    chk("word_idx", {25'd0, word_idx}, {25'd0, ei});
    chk("align_err", {31'd0, align_err}, {31'd0, er});
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_dout"}, dout, 32'h0);
    chk({tag, "_valid"}, {31'd0, dout_valid}, 32'h0);
    chk({tag, "_sob"}, {31'd0, dout_sob}, 32'h0);
    chk({tag, "_eob"}, {31'd0, dout_eob}, 32'h0);
    chk({tag, "_idx"}, {25'd0, word_idx}, 32'h0);
    chk({tag, "_err"}, {31'd0, align_err}, 32'h0);
  endtask

  initial begin
    logic [31:0] d;
    int          eobs;
    build_pn();
    chk("pn_tbl0", pn[0], 32'hFFFFFFFF);
    chk("pn_tbl1", pn[1], 32'h02AAAAFF);
    din = '0; din_valid = 0; din_sob = 0;
`ifdef PN2112_CHECK_EN
    chk_clr = 0;
`endif
    m_in = 0; m_idx = 0;

    // Power-on reset
    arst = 1;
    #1;
    check_zero("reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    arst = 0;

    // Words before any sob are discarded
    for (int i = 0; i < 5; i++) cyc(1, 0, $urandom);
    d = $urandom;
    cyc(1, 1, d);
    chk("first_sob", dout, d ^ 32'hFFFFFFFF);
    for (int n = 1; n < 66; n++) cyc(1, 0, $urandom);
    cyc(0, 0, 32'h0);

    // All-zero block exposes the PN sequence
    eobs = 0;
    for (int n = 0; n < 66; n++) begin
      cyc(1, n == 0, 32'h0);
      if (n == 0) chk("pn_w0_out", dout, 32'hFFFFFFFF);
      if (n == 1) chk("pn_w1_out", dout, 32'h02AAAAFF);
      if (dout_eob) begin
        eobs++;
        chk("eob_idx", {25'd0, word_idx}, 32'd65);
      end
    end
    chk("eob_count", eobs, 32'd1);
    cyc(0, 0, 32'h0);

    // PN words in give zero out
    for (int n = 0; n < 66; n++) begin
      cyc(1, n == 0, pn[n]);
      chk("pn_cancel", dout, 32'h0);
    end

    // Random gaps inside a block
    for (int n = 0; n < 66; n++) begin
      while ($urandom_range(1) == 0) cyc(0, 0, $urandom);
      cyc(1, n == 0, $urandom);
    end
    cyc(0, 0, 32'h0);

    // Realignment at word 10, then back-to-back blocks
    for (int n = 0; n < 10; n++) cyc(1, n == 0, $urandom);
    cyc(1, 1, $urandom);
    chk("realign_err", {31'd0, align_err}, 32'd1);
    chk("realign_idx", {25'd0, word_idx}, 32'd0);
    d = $urandom;
    cyc(1, 0, d);
    chk("realign_w1", dout, d ^ 32'h02AAAAFF);
    chk("realign_pulse", {31'd0, align_err}, 32'd0);
    for (int n = 2; n < 66; n++) cyc(1, 0, $urandom);
    cyc(1, 1, $urandom);
    chk("b2b_no_err", {31'd0, align_err}, 32'd0);
    for (int n = 1; n < 66; n++) cyc(1, 0, $urandom);

    // Reset at word 30
    for (int n = 0; n < 30; n++) cyc(1, n == 0, $urandom);
    arst = 1;
    #1;
    check_zero("midrst");
    m_in = 0; m_idx = 0;
    din_valid = 0; din_sob = 0;
    @(posedge clk); #1;
    arst = 0;
    for (int i = 0; i < 4; i++) cyc(1, 0, $urandom);
    for (int n = 0; n < 66; n++) cyc(1, n == 0, $urandom);
    cyc(0, 0, 32'h0);

`ifdef PN2112_CHECK_EN
    chk_clr = 1;
    @(posedge clk); #1;
    chk_clr = 0;
    chk("cnt_clr0", chk_err_cnt, 32'd0);
    for (int n = 0; n < 66; n++) begin
      d = pn[n];
      if (n == 5) d[0] = ~d[0];
      cyc(1, n == 0, d);
    end
    cyc(0, 0, 32'h0);
    chk("cnt_one", chk_err_cnt, 32'd1);
    chk_clr = 1;
    @(posedge clk); #1;
    chk_clr = 0;
    chk("cnt_clr1", chk_err_cnt, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pn2112_descrambler.md
Name: pn2112_descrambler

Overview:
- Receive-side counterpart of the PN-2112 generator used by the 10GBASE-R FEC path.
- Takes 32-bit words of a received 2112-bit FEC block (66 words), aligned by a start-of-block strobe.
- XORs each word with the matching PN-2112 word to strip the block scrambling.
- Sits between the FEC block-sync/gearbox stage and the FEC decoder.

Parameters:
- SEED, 58'h2aaaaaaaaaaaaaa, LFSR load value at every start of block.
- WORDS_PER_BLOCK, 66, words per FEC block (2112/32).

Ports:
- clk  in  1  single clock.
- arst  in  1  asynchronous reset, active high.
- din  in  32  received word; din[0] is the earliest bit on the line.
- din_valid  in  1  din is valid this cycle.
- din_sob  in  1  din is word 0 of a block; ignored unless din_valid.
- dout  out  32  descrambled word.
- dout_valid  out  1  dout is valid.
- dout_sob  out  1  dout is word 0 of a block.
- dout_eob  out  1  dout is word 65 of a block.
- word_idx  out  7  index (0..65) of the word currently on dout.
- align_err  out  1  one-cycle pulse: din_sob arrived while a block was in progress.

Behaviour:
- PN generation
  - Polynomial x^58+x^39+1.
  - Each step: out = s[57]^s[38]; s <= {s[56:0], out}.
  - The register is loaded with SEED at each block start.
  - PN bit t (t = 0..2111) is the out of step t. Word n uses bits t = 32n..32n+31, with bit 32n in position 0.
  - Known words: PN word 0 = 32'hFFFFFFFF; PN word 1 = 32'h02AAAAFF.
- Datapath
  - dout = din ^ PN word[idx], registered.
  - Latency is exactly 1 cycle from din_valid to dout_valid.
  - No backpressure. din_valid may be low for any number of cycles; the PN state and word index hold while it is low.
- State machine
  - HUNT (reset state):
    - din_valid with din_sob: emit using PN word 0, go to IN_BLOCK with next idx = 1.
    - din_valid without din_sob: word is discarded (dout_valid = 0).
  - IN_BLOCK:
    - din_valid without din_sob: emit using PN word[idx], then idx++.
    - After emitting word 65, go to HUNT.
    - din_valid with din_sob mid-block (idx 1..65): restart at PN word 0, pulse align_err with that output word, stay IN_BLOCK with idx = 1.
- Flags
  - Back-to-back blocks (sob in the cycle after word 65) are legal and do not raise align_err.
  - dout_sob, dout_eob and word_idx are valid only while dout_valid = 1. They are 0 otherwise.
- Reset
  - Reset values: dout = 0, dout_valid = 0, dout_sob = 0, dout_eob = 0, word_idx = 0, align_err = 0.
  - State returns to HUNT and the LFSR loads SEED.
  - Reset mid-block abandons the block. The next output comes only after a new din_sob.
- Implementation
  - The PN source may be a 32-step LFSR advance per word or a 66-entry ROM.
  - Outputs must be bit-identical for both.

Optional Feature:
- Macro: PN2112_CHECK_EN.
- When defined, adds these ports:
  - chk_err_cnt  out  32
  - chk_clr  in  1
- Behaviour when defined:
  - Each emitted word adds popcount(dout) to chk_err_cnt, saturating at 32'hFFFFFFFF.
  - This supports line checking with an all-zero scrambled payload.
  - chk_clr clears the counter synchronously and takes priority over an increment in the same cycle.
  - arst clears the counter.
- When not defined: no extra ports, no counter logic.
- Descrambler datapath timing is identical in both builds.

Test Plan:
- Block of 66 words of din = 32'h0, sob on word 0, contiguous:
  - dout word 0 = 32'hFFFFFFFF, word 1 = 32'h02AAAAFF.
  - All 66 words match the reference PN table.
  - dout_eob = 1 only with word_idx = 65.
  - Then din = PN word n must give dout = 0 for all 66 words.
- Random din_valid gaps (~50% duty) inside a block: dout equals the gap-free result word-for-word. Latency is 1 cycle per accepted word.
- din_valid words before any sob after reset: dout_valid stays 0. First sob word gives dout = din ^ 32'hFFFFFFFF.
- sob at word 10 of a block:
  - align_err pulses once with word_idx = 0.
  - Next word uses PN word 1.
  - Back-to-back sob after word 65: no align_err.
- arst asserted at word 30: all outputs go to 0 immediately. After release, non-sob words are discarded until sob.
- With PN2112_CHECK_EN, one block of PN words with din bit 0 of word 5 flipped: chk_err_cnt = 1. After chk_clr: chk_err_cnt = 0.
